// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder.
// The master side issues operations, the slave side (the adder) returns results.
interface serial_adder_if #(
   parameter int WIDTH = 16
) ();

   // Request side
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;

   // Result side
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             overflow;

   modport master (
      output start,
      output a,
      output b,
      output cin,
      output sub,
      input  busy,
      input  done,
      input  sum,
      input  carry,
      input  overflow
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      input  cin,
      input  sub,
      output busy,
      output done,
      output sum,
      output carry,
      output overflow
   );

endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-add cell plus a carry register,
// processing one bit per clock, LSB first. Subtraction is A + ~B + 1.
// Three-state control: IDLE -> RUN (WIDTH cycles) -> DONE (1 cycle) -> IDLE.
module serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);

   // Counter only has to reach WIDTH-1; keep it at least one bit wide.
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;

   // Operand shift registers; b_reg already holds ~b in subtract mode.
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   // Partial result, filled from the MSB end as bits are produced.
   logic [WIDTH-1:0] res_reg;
   logic             c_reg;
   logic [CNT_W-1:0] cnt_reg;

   // Registered outputs
   logic [WIDTH-1:0] sum_reg;
   logic             carry_reg;
   logic             ovf_reg;
   logic             busy_reg;
   logic             done_reg;

   // Full-add cell signals
   logic             a_bit;
   logic             b_bit;
   logic             s_bit;
   logic             c_next;
   logic [WIDTH-1:0] res_next;
   logic             last_step;

   // One full-add cell on the current LSBs of the operand shift registers.
   always_comb begin
      a_bit     = a_reg[0];
      b_bit     = b_reg[0];
      s_bit     = a_bit ^ b_bit ^ c_reg;
      c_next    = (a_bit & b_bit) | (a_bit & c_reg) | (b_bit & c_reg);
      last_step = (cnt_reg == LAST_BIT);
   end

   // New result bit enters at the MSB so that after WIDTH steps the
   // first-computed bit has walked down to bit 0.
   generate
      if (WIDTH == 1) begin : g_res_single
         assign res_next = s_bit;
      end else begin : g_res_multi
         assign res_next = {s_bit, res_reg[WIDTH-1:1]};
      end
   endgenerate

   // Control FSM, datapath registers and registered outputs.
   // On the last step c_reg is the carry into the MSB and c_next the carry
   // out of it, so their XOR is the signed overflow (for WIDTH=1 c_reg is
   // still the initial carry, which is exactly what is wanted).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         c_reg     <= 1'b0;
         cnt_reg   <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         ovf_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (bus.start) begin
                  a_reg     <= bus.a;
                  b_reg     <= bus.sub ? ~bus.b : bus.b;
                  c_reg     <= bus.sub ? 1'b1 : bus.cin;
                  res_reg   <= '0;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= RUN;
               end
            end

            RUN: begin
               a_reg   <= a_reg >> 1;
               b_reg   <= b_reg >> 1;
               res_reg <= res_next;
               c_reg   <= c_next;
               cnt_reg <= cnt_reg + CNT_W'(1);
               if (last_step) begin
                  sum_reg   <= res_next;
                  carry_reg <= c_next;
                  ovf_reg   <= c_reg ^ c_next;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end

            DONE: begin
               // start is deliberately not looked at here: it is only
               // honoured once back in IDLE.
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Drive the result side of the bundle straight from registers.
   always_comb begin
      bus.busy     = busy_reg;
      bus.done     = done_reg;
      bus.sum      = sum_reg;
      bus.carry    = carry_reg;
      bus.overflow = ovf_reg;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; legal range 1..64.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured at the start-accept edge.
REQ-006 b  input  WIDTH  operand B, captured at the start-accept edge.
REQ-007 cin  input  1  carry-in for add; ignored when sub=1.
REQ-008 sub  input  1  mode, captured at the start-accept edge: 0 = A+B+cin, 1 = A-B.
REQ-009 busy  output  1  high while an operation is in progress (RUN).
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 sum  output  WIDTH  result; holds the last completed value.
REQ-012 carry  output  1  carry out of the MSB; in sub mode 1 = no borrow.
REQ-013 overflow  output  1  signed two's-complement overflow of the last result.

Function
REQ-014 The block SHALL compute one result bit per clock, LSB first, using one full-add cell and a carry register.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 IDLE with start=1 at an edge (the accept edge E0) SHALL do all of the following: capture a, b, sub and cin; load the carry register with 1 if sub=1, else cin; clear the bit counter; go to RUN.
REQ-017 In sub mode the block SHALL use ~b as the second operand, so that the result is A + ~B + 1.
REQ-018 In RUN, edge Ek (k=1..WIDTH) SHALL process bit k-1.
REQ-019 Each RUN bit step SHALL compute s = a ^ b' ^ c and c_next = majority(a, b', c).
REQ-020 Each RUN bit step SHALL shift s into an internal result register and update the carry register with c_next.
REQ-021 At edge E_WIDTH the state SHALL go to DONE.
REQ-022 At the same edge E_WIDTH, sum, carry and overflow SHALL be loaded from the internal registers.
REQ-023 overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-024 For WIDTH=1, the carry into the MSB SHALL be the initial carry.
REQ-025 DONE SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-026 done SHALL be registered and equal to (state==DONE).
REQ-027 busy SHALL be registered and equal to (state==RUN).
REQ-028 Latency: done SHALL be high in the cycle following edge E_WIDTH.
REQ-029 Throughput: with start held high, successive operations SHALL be accepted every WIDTH+2 cycles.
REQ-030 start asserted in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-031 Changes on a, b, cin or sub after E0 SHALL NOT affect the operation in progress.
REQ-032 sum, carry and overflow SHALL change only at the transition into DONE and SHALL hold through the following RUN, until the next completion.

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE and busy=0, done=0, sum=0, carry=0, overflow=0, and clear all internal registers, independent of clk.
REQ-034 Assertion of rst_n=0 mid-RUN SHALL abort the operation with no done pulse.
REQ-035 The first start after reset release SHALL be accepted at the first rising edge with rst_n=1 in IDLE.

Verification (WIDTH=8)
REQ-036 Basic add, a=0x35, b=0x4A, cin=0, sub=0: done=1 exactly in the cycle after the 8th edge following E0, with sum=0x7F, carry=0, overflow=0; busy=1 for 8 cycles.
REQ-037 Unsigned wrap, a=0xFF, b=0x01, cin=0: sum=0x00, carry=1, overflow=0.
REQ-038 Carry-in, a=0xFF, b=0x00, cin=1: sum=0x00, carry=1, overflow=0.
REQ-039 Signed overflow, a=0x7F, b=0x01, cin=0: sum=0x80, carry=0, overflow=1.
REQ-040 Subtract, a=0x05, b=0x07, sub=1, cin=1: sum=0xFE, carry=0, overflow=0 (cin ignored).
REQ-041 Subtract, a=0x80, b=0x01, sub=1: sum=0x7F, carry=1, overflow=1.
REQ-042 Robustness: pulse rst_n low after 3 RUN cycles, then outputs=0 immediately, no done pulse, and a new start gives a correct result.
REQ-043 Robustness: with start held high and operands changed mid-RUN, the results match the captured operands, done pulses are 10 cycles apart, and sum holds between pulses.
